// File: rtl/bit_serial_add_ctrl_if.sv
// Request/result bundle between a requester and bit_serial_add_ctrl.
// With SUBTRACT_EN defined, the bundle also carries the sub request bit and the ovf result flag.
interface bit_serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SUBTRACT_EN
    logic             sub;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared 1-bit full adder, LSB first, one bit per clock.
// Optional macro SUBTRACT_EN adds a-b mode (sub input) and a signed overflow flag (ovf).
//
// state | meaning
// IDLE  | ready=1, waiting for start; sum/cout hold last result
// RUN   | busy=1, one operand bit per edge through the full adder
// DONE  | done=1 for one cycle, sum/cout valid

module bit_serial_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p;
    logic g;
    logic t;

    xor u_x0 (p, a, b);
    xor u_x1 (sum, p, cin);
    and u_a0 (g, a, b);
    and u_a1 (t, cin, p);
    or  u_o0 (cout, g, t);
endmodule

module bit_serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bit_serial_add_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] r_next;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    bit_serial_fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign r_next   = {fa_sum, r_sh[WIDTH-1:1]};
    assign accept   = (state_q == IDLE) && bus.start;

`ifdef SUBTRACT_EN
    logic ovf_q;

    // Subtract as a + ~b + 1; cin is deliberately ignored in this mode.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
    assign bus.ovf    = ovf_q;

    // carry still holds the carry into the MSB on the final RUN edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf_q <= carry ^ fa_cout;
        end
    end
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            r_sh  <= '0;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_next;
            carry <= fa_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= r_next;
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
Sequencer that time-shares one 1-bit full adder (sum = a^b^cin, cout = a&b | cin&(a^b)) to add two WIDTH-bit operands.
- Processes one bit per clock, LSB first.
- Holds the carry in a flop between bits.
- Shifts sum bits into a result register.
- Sits between a requester (start/ready/done handshake) and downstream logic that consumes sum/cout.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result
cout  output  1  registered final carry

Behaviour:
- States:
  - IDLE: ready=1.
  - RUN: busy=1.
  - DONE: done=1.
  - Encoding is implementer's choice.
- Reset: rst_n=0 at a rising edge forces:
  - state=IDLE; sum=0; cout=0; done=0; busy=0; ready=1.
  - Internal shift registers, carry flop and counter all cleared.
  - Applies in any state, including mid-RUN. The partial result is discarded and no done pulse is produced.
- IDLE:
  - start=1 at an edge: A_sh<=a, B_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - start=0: stay in IDLE; sum/cout hold their previous values.
- RUN, each edge:
  - Full adder evaluates A_sh[0], B_sh[0], carry.
  - Sum bit shifts into R_sh MSB (R_sh >> 1). A_sh and B_sh shift right by 1.
  - carry <= fa_cout; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum<=final R_sh (including this bit), cout<=fa_cout, state<=DONE.
- DONE: done=1 for exactly one cycle, then state<=IDLE on the next edge.
- Latency:
  - Start accepted at edge E0; bits are processed at edges E1..E_WIDTH.
  - done is high in the cycle after E_WIDTH, i.e. after WIDTH edges following E0.
  - Throughput is one operation per WIDTH+2 cycles.
- sum/cout are updated only at the final RUN edge. They are stable from done until the completion of the next operation, and hold through IDLE.
- start while busy or done is ignored: no queueing, no effect on the in-flight operation.
- a/b/cin changing after the accepting edge have no effect.
- start held high continuously: a new operation is accepted in each IDLE cycle, so back-to-back operations are spaced WIDTH+2 cycles apart.
- The full adder is a separate combinational cell built from xor/and/or primitives, instantiated once. No WIDTH-bit adder may be inferred.

Optional Feature:
Macro SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepting edge.
  - sub=1 means B_sh<=~b and carry<=1 (cin ignored), computing a-b in two's complement. cout=1 means no borrow.
  - Adds output ovf (1 bit), registered at the final RUN edge: ovf = carry_into_MSB ^ fa_cout of the MSB.
  - ovf resets to 0.
- Undefined: no sub/ovf ports; the block is add-only, and behaviour is as above.

Test Plan:
1. WIDTH=8; reset, then start with a=0x00, b=0x00, cin=0 -> done pulses exactly 8 edges after acceptance; sum=0x00, cout=0, busy high for 8 cycles.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
3. Mid-RUN start pulse with a=0x11, b=0x22 during an operation on a=0x0F, b=0x01 -> ignored; result sum=0x10, cout=0; exactly one done pulse.
4. Reset mid-operation: rst_n=0 at the 4th RUN edge -> next cycle state=IDLE, ready=1, sum=0, cout=0; no done for 20 cycles without a new start.
5. start tied high, three operands 0x01+0x01, 0x7F+0x01, 0x80+0x80 -> done pulses spaced 10 cycles apart; results 0x02/0, 0x80/0, 0x00/1.
6. SUBTRACT_EN defined, sub=1: a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
